// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode stage: instruction codes, register IDs,
// the D-register field bundle and the decode FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // valP lives beside this struct because its width is a per-instance parameter
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ra;
    logic [3:0] rb;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{icode: I_NOP, ra: RNONE, rb: RNONE};

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_RET = 1'b1
  } state_e;

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

  // RNONE is never a real producer, so it can never match
  function automatic logic reg_match(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/decode_fwd_ctrl_if.sv
// Signal bundle between the decode stage and its neighbours (fetch, register file,
// execute/memory/write-back forwarding sources, E register).
interface decode_fwd_ctrl_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       f_icode;
  logic [3:0]       f_rA;
  logic [3:0]       f_rB;
  logic [WIDTH-1:0] f_valP;

  logic [3:0]       rf_srcA;
  logic [3:0]       rf_srcB;
  logic [WIDTH-1:0] rf_valA;
  logic [WIDTH-1:0] rf_valB;

  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_mispredict;

  logic [3:0]       e_dstE;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       M_dstE;
  logic [WIDTH-1:0] M_valE;
  logic [3:0]       M_dstM;
  logic [WIDTH-1:0] m_valM;
  logic [3:0]       W_dstE;
  logic [WIDTH-1:0] W_valE;
  logic [3:0]       W_dstM;
  logic [WIDTH-1:0] W_valM;

  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       d_dstE;
  logic [3:0]       d_dstM;
  logic [WIDTH-1:0] d_valA;
  logic [WIDTH-1:0] d_valB;

  logic             f_stall;
  logic             d_bubble;

  modport slave (
    input  f_icode, f_rA, f_rB, f_valP,
    output rf_srcA, rf_srcB,
    input  rf_valA, rf_valB,
    input  E_icode, E_dstM, e_mispredict,
    input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    input  W_dstE, W_valE, W_dstM, W_valM,
    output D_icode, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB,
    output f_stall, d_bubble
  );

  modport master (
    output f_icode, f_rA, f_rB, f_valP,
    input  rf_srcA, rf_srcB,
    output rf_valA, rf_valB,
    output E_icode, E_dstM, e_mispredict,
    output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    output W_dstE, W_valE, W_dstM, W_valM,
    input  D_icode, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB,
    input  f_stall, d_bubble
  );
endinterface

// File: rtl/fwd_mux.sv
// Priority operand select for one decode source; DECODE_FWD_EN enables the
// pipeline forwarding terms, otherwise only valP / register-file data are used.
module fwd_mux
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             en_valp,
  input  logic [3:0]       icode,
  input  logic [WIDTH-1:0] valp,
  input  logic [3:0]       src,
  input  logic [3:0]       e_dstE,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [3:0]       M_dstM,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [3:0]       M_dstE,
  input  logic [WIDTH-1:0] M_valE,
  input  logic [3:0]       W_dstM,
  input  logic [WIDTH-1:0] W_valM,
  input  logic [3:0]       W_dstE,
  input  logic [WIDTH-1:0] W_valE,
  input  logic [WIDTH-1:0] rf_val,
  output logic [WIDTH-1:0] val
);

  logic use_valp;
  assign use_valp = en_valp && ((icode == I_JXX) || (icode == I_CALL));

`ifdef DECODE_FWD_EN
  // youngest producer wins; memory load result beats the ALU result in M
  always_comb begin
    val = rf_val;
    if (use_valp)                     val = valp;
    else if (reg_match(src, e_dstE))  val = e_valE;
    else if (reg_match(src, M_dstM))  val = m_valM;
    else if (reg_match(src, M_dstE))  val = M_valE;
    else if (reg_match(src, W_dstM))  val = W_valM;
    else if (reg_match(src, W_dstE))  val = W_valE;
  end
`else
  always_comb begin
    val = rf_val;
    if (use_valp) val = valp;
  end

  logic fwd_unused;
  assign fwd_unused = ^{src, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                        W_dstM, W_valM, W_dstE, W_valE};
`endif

endmodule

// File: rtl/decode_fwd_ctrl.sv
// Y86-64 decode stage: D register, register-ID decode, operand forwarding and
// load-use / ret / mispredict control. DECODE_FWD_EN selects forwarding vs interlock-only.
//
//   state  | meaning
//   RUN    | normal decode, D loads from fetch unless stalled
//   RET    | ret left decode; D fed bubbles while cnt counts down
module decode_fwd_ctrl
  import y86_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int RET_BUBBLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  decode_fwd_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(RET_BUBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(RET_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  d_reg_t           d_q;
  logic [WIDTH-1:0] d_valp;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic [3:0] src_a, src_b, dst_e, dst_m;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = d_q.ra;
      I_RET, I_POPQ:                      src_a = RSP;
      default:                            src_a = RNONE;
    endcase
    case (d_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP;
      default:                            src_b = RNONE;
    endcase
    case (d_q.icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP;
      default:                            dst_e = RNONE;
    endcase
    case (d_q.icode)
      I_MRMOVQ, I_POPQ:                   dst_m = d_q.ra;
      default:                            dst_m = RNONE;
    endcase
  end

  logic load_use, data_stall;
  assign load_use = is_load(bus.E_icode) && (bus.E_dstM != RNONE) &&
                    ((bus.E_dstM == src_a) || (bus.E_dstM == src_b));

`ifdef DECODE_FWD_EN
  assign data_stall = load_use;
`else
  // without forwarding, any in-flight writer of a source blocks decode
  logic hit_a, hit_b;
  assign hit_a = reg_match(src_a, bus.e_dstE) || reg_match(src_a, bus.M_dstE) ||
                 reg_match(src_a, bus.M_dstM) || reg_match(src_a, bus.W_dstE) ||
                 reg_match(src_a, bus.W_dstM);
  assign hit_b = reg_match(src_b, bus.e_dstE) || reg_match(src_b, bus.M_dstE) ||
                 reg_match(src_b, bus.M_dstM) || reg_match(src_b, bus.W_dstE) ||
                 reg_match(src_b, bus.W_dstM);
  assign data_stall = load_use || hit_a || hit_b;
`endif

  logic hold_d, ret_start, in_ret;
  assign hold_d    = !bus.e_mispredict && data_stall;
  assign ret_start = !bus.e_mispredict && !data_stall && (state == ST_RUN) &&
                     (d_q.icode == I_RET);
  assign in_ret    = !bus.e_mispredict && !data_stall && (state == ST_RET);

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= D_BUBBLE;
      d_valp <= '0;
      state  <= ST_RUN;
      cnt    <= '0;
    end else if (bus.e_mispredict) begin
      d_q    <= D_BUBBLE;
      d_valp <= '0;
      state  <= ST_RUN;
      cnt    <= '0;
    end else if (data_stall) begin
      d_q    <= d_q;
      d_valp <= d_valp;
    end else if (state == ST_RUN && d_q.icode == I_RET) begin
      d_q    <= D_BUBBLE;
      d_valp <= '0;
      if (RET_BUBBLES > 1) begin
        state <= ST_RET;
        cnt   <= CNT_START;
      end
    end else if (state == ST_RET) begin
      d_q    <= D_BUBBLE;
      d_valp <= '0;
      if (cnt <= CNT_ONE) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end else begin
      d_q    <= '{icode: bus.f_icode, ra: bus.f_rA, rb: bus.f_rB};
      d_valp <= bus.f_valP;
    end
  end

  logic [WIDTH-1:0] val_a, val_b;

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .en_valp (1'b1),
    .icode   (d_q.icode),
    .valp    (d_valp),
    .src     (src_a),
    .e_dstE  (bus.e_dstE),
    .e_valE  (bus.e_valE),
    .M_dstM  (bus.M_dstM),
    .m_valM  (bus.m_valM),
    .M_dstE  (bus.M_dstE),
    .M_valE  (bus.M_valE),
    .W_dstM  (bus.W_dstM),
    .W_valM  (bus.W_valM),
    .W_dstE  (bus.W_dstE),
    .W_valE  (bus.W_valE),
    .rf_val  (bus.rf_valA),
    .val     (val_a)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .en_valp (1'b0),
    .icode   (d_q.icode),
    .valp    (d_valp),
    .src     (src_b),
    .e_dstE  (bus.e_dstE),
    .e_valE  (bus.e_valE),
    .M_dstM  (bus.M_dstM),
    .m_valM  (bus.m_valM),
    .M_dstE  (bus.M_dstE),
    .M_valE  (bus.M_valE),
    .W_dstM  (bus.W_dstM),
    .W_valM  (bus.W_valM),
    .W_dstE  (bus.W_dstE),
    .W_valE  (bus.W_valE),
    .rf_val  (bus.rf_valB),
    .val     (val_b)
  );

  assign bus.D_icode  = d_q.icode;
  assign bus.d_srcA   = src_a;
  assign bus.d_srcB   = src_b;
  assign bus.d_dstE   = dst_e;
  assign bus.d_dstM   = dst_m;
  assign bus.rf_srcA  = src_a;
  assign bus.rf_srcB  = src_b;
  assign bus.d_valA   = val_a;
  assign bus.d_valB   = val_b;
  assign bus.f_stall  = hold_d || ret_start || in_ret;
  assign bus.d_bubble = hold_d;

endmodule

// File: tb/tb_decode_fwd_ctrl.sv
// Directed bench for decode_fwd_ctrl; expectations follow the build mode
// selected by DECODE_FWD_EN (forwarding vs interlock-only).
module tb_decode_fwd_ctrl;
  import y86_pkg::*;

`ifdef DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [63:0] RFA = 64'hA1A1;
  localparam logic [63:0] RFB = 64'hB2B2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_fwd_ctrl_if #(.WIDTH(64)) bus ();

  decode_fwd_ctrl #(.WIDTH(64), .RET_BUBBLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] icode, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] valp);
    bus.f_icode = icode;
    bus.f_rA    = ra;
    bus.f_rB    = rb;
    bus.f_valP  = valp;
  endtask

  task automatic clear_fwd();
    bus.E_icode      = I_NOP;
    bus.E_dstM       = RNONE;
    bus.e_mispredict = 1'b0;
    bus.e_dstE = RNONE; bus.e_valE = '0;
    bus.M_dstE = RNONE; bus.M_valE = '0;
    bus.M_dstM = RNONE; bus.m_valM = '0;
    bus.W_dstE = RNONE; bus.W_valE = '0;
    bus.W_dstM = RNONE; bus.W_valM = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_fwd();
    set_fetch(I_NOP, RNONE, RNONE, 64'h0);
    bus.rf_valA = RFA;
    bus.rf_valB = RFB;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // reset state
    check("rst_icode",  bus.D_icode, 64'h1);
    check("rst_srcA",   bus.d_srcA, 64'hF);
    check("rst_srcB",   bus.d_srcB, 64'hF);
    check("rst_dstE",   bus.d_dstE, 64'hF);
    check("rst_dstM",   bus.d_dstM, 64'hF);
    check("rst_valA",   bus.d_valA, RFA);
    check("rst_valB",   bus.d_valB, RFB);
    check("rst_fstall", bus.f_stall, 64'h0);
    check("rst_bubble", bus.d_bubble, 64'h0);

    // opq %rax,%rbx enters D; irmovq $..,%rbp waits in fetch
    set_fetch(I_OPQ, 4'h0, 4'h3, 64'h100);
    tick();
    set_fetch(I_IRMOVQ, RNONE, 4'h5, 64'h200);
    #1;
    check("opq_icode", bus.D_icode, 64'h6);
    check("opq_rfsrcA", bus.rf_srcA, 64'h0);
    check("opq_rfsrcB", bus.rf_srcB, 64'h3);
    check("opq_dstE", bus.d_dstE, 64'h3);
    check("opq_dstM", bus.d_dstM, 64'hF);
    check("opq_valA", bus.d_valA, RFA);

    // forwarding priority: e beats M on the same register
    bus.e_dstE = 4'h0; bus.e_valE = 64'd9;
    bus.M_dstE = 4'h0; bus.M_valE = 64'd5;
    #1;
    check("prio_e_over_M", bus.d_valA, FWD ? 64'd9 : RFA);
    check("prio_fstall", bus.f_stall, FWD ? 64'h0 : 64'h1);
    check("prio_bubble", bus.d_bubble, FWD ? 64'h0 : 64'h1);
    bus.e_dstE = RNONE;
    #1;
    check("prio_M_valE", bus.d_valA, FWD ? 64'd5 : RFA);
    bus.M_dstM = 4'h3; bus.m_valM = 64'd77;
    bus.W_dstE = 4'h3; bus.W_valE = 64'd55;
    bus.W_dstM = 4'h3; bus.W_valM = 64'd66;
    #1;
    check("prio_m_valM", bus.d_valB, FWD ? 64'd77 : RFB);
    bus.M_dstM = RNONE;
    #1;
    check("prio_W_valM", bus.d_valB, FWD ? 64'd66 : RFB);
    bus.W_dstM = RNONE;
    #1;
    check("prio_W_valE", bus.d_valB, FWD ? 64'd55 : RFB);

    // write-back hazard on rA: interlock build stalls until it clears
    clear_fwd();
    bus.W_dstE = 4'h0; bus.W_valE = 64'd33;
    #1;
    check("wb_fstall", bus.f_stall, FWD ? 64'h0 : 64'h1);
    check("wb_valA", bus.d_valA, FWD ? 64'd33 : RFA);
    tick();
    check("wb_hold_icode", bus.D_icode, FWD ? 64'h3 : 64'h6);
    check("wb_fstall2", bus.f_stall, FWD ? 64'h0 : 64'h1);
    bus.W_dstE = RNONE;
    #1;
    check("wb_clear_fstall", bus.f_stall, 64'h0);
    check("wb_clear_valA", bus.d_valA, RFA);
    tick();
    check("irm_icode", bus.D_icode, 64'h3);
    check("irm_dstE", bus.d_dstE, 64'h5);

    // a RNONE source never matches a RNONE destination
    bus.e_dstE = RNONE; bus.e_valE = 64'h999;
    #1;
    check("rnone_valA", bus.d_valA, RFA);
    check("rnone_fstall", bus.f_stall, 64'h0);
    clear_fwd();

    // load-use: mrmovq ..,%rbx in E, addq %rcx,%rbx in D
    set_fetch(I_OPQ, 4'h1, 4'h3, 64'h300);
    tick();
    set_fetch(I_NOP, RNONE, RNONE, 64'h302);
    bus.E_icode = I_MRMOVQ; bus.E_dstM = 4'h3;
    #1;
    check("lu_fstall", bus.f_stall, 64'h1);
    check("lu_bubble", bus.d_bubble, 64'h1);
    tick();
    check("lu_hold_icode", bus.D_icode, 64'h6);
    check("lu_hold_srcB", bus.d_srcB, 64'h3);
    bus.E_icode = I_NOP; bus.E_dstM = RNONE;
    bus.M_dstM = 4'h3; bus.m_valM = 64'h4444;
    #1;
    check("lu_next_valB", bus.d_valB, FWD ? 64'h4444 : RFB);
    check("lu_next_fstall", bus.f_stall, FWD ? 64'h0 : 64'h1);
    check("lu_next_bubble", bus.d_bubble, FWD ? 64'h0 : 64'h1);
    clear_fwd();

    // mispredict overrides a load-use hazard: bubble, no hold
    bus.E_icode = I_MRMOVQ; bus.E_dstM = 4'h3; bus.e_mispredict = 1'b1;
    set_fetch(I_IRMOVQ, RNONE, 4'h5, 64'h210);
    tick();
    check("mp_icode", bus.D_icode, 64'h1);
    check("mp_srcB", bus.d_srcB, 64'hF);
    clear_fwd();

    // ret: three stall cycles, three bubbles, then the fetched instruction
    set_fetch(I_RET, RNONE, RNONE, 64'h50);
    tick();
    set_fetch(I_IRMOVQ, RNONE, 4'h7, 64'h500);
    #1;
    check("ret_icode", bus.D_icode, 64'h9);
    check("ret_fstall0", bus.f_stall, 64'h1);
    check("ret_bubble0", bus.d_bubble, 64'h0);
    check("ret_srcA", bus.d_srcA, 64'h4);
    check("ret_dstE", bus.d_dstE, 64'h4);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("ret_bub_icode%0d", i), bus.D_icode, 64'h1);
      check($sformatf("ret_fstall%0d", i), bus.f_stall, (i < 3) ? 64'h1 : 64'h0);
    end
    tick();
    check("ret_after_icode", bus.D_icode, 64'h3);
    check("ret_after_dstE", bus.d_dstE, 64'h7);

    // reset while the ret sequence has cnt = 2
    set_fetch(I_RET, RNONE, RNONE, 64'h60);
    tick();
    set_fetch(I_IRMOVQ, RNONE, 4'h7, 64'h510);
    tick();
    check("rret_fstall", bus.f_stall, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rret_icode", bus.D_icode, 64'h1);
    check("rret_fstall_clr", bus.f_stall, 64'h0);
    tick();
    check("rret_run_icode", bus.D_icode, 64'h3);

    // mispredict cancels a ret sequence
    set_fetch(I_RET, RNONE, RNONE, 64'h70);
    tick();
    set_fetch(I_IRMOVQ, RNONE, 4'h7, 64'h520);
    tick();
    bus.e_mispredict = 1'b1;
    tick();
    bus.e_mispredict = 1'b0;
    #1;
    check("mret_fstall", bus.f_stall, 64'h0);
    check("mret_icode", bus.D_icode, 64'h1);
    tick();
    check("mret_run_icode", bus.D_icode, 64'h3);

    // valP selection for jXX and call
    set_fetch(I_JXX, RNONE, RNONE, 64'h700);
    tick();
    check("jxx_valA", bus.d_valA, 64'h700);
    check("jxx_valB", bus.d_valB, RFB);
    set_fetch(I_CALL, RNONE, RNONE, 64'h800);
    tick();
    check("call_valA", bus.d_valA, 64'h800);
    check("call_srcB", bus.d_srcB, 64'h4);
    check("call_dstE", bus.d_dstE, 64'h4);
    check("call_fstall", bus.f_stall, 64'h0);

    // ret in D behind popq %rsp in E: stall first, then the ret sequence
    set_fetch(I_RET, RNONE, RNONE, 64'h90);
    tick();
    set_fetch(I_IRMOVQ, RNONE, 4'h7, 64'h530);
    bus.E_icode = I_POPQ; bus.E_dstM = 4'h4;
    #1;
    check("luret_fstall", bus.f_stall, 64'h1);
    check("luret_bubble", bus.d_bubble, 64'h1);
    tick();
    check("luret_hold_icode", bus.D_icode, 64'h9);
    clear_fwd();
    #1;
    check("luret_bubble_clr", bus.d_bubble, 64'h0);
    check("luret_fstall0", bus.f_stall, 64'h1);
    tick();
    check("luret_fstall1", bus.f_stall, 64'h1);
    tick();
    check("luret_fstall2", bus.f_stall, 64'h1);
    tick();
    check("luret_fstall3", bus.f_stall, 64'h0);
    check("luret_icode3", bus.D_icode, 64'h1);
    tick();
    check("luret_after_icode", bus.D_icode, 64'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
